// File: rtl/tnn_pkg.sv
// Shared types and default widths for the ternary-neuron accumulator slice.
package tnn_pkg;

  localparam int unsigned CNT_W_DEFAULT   = 5;
  localparam int unsigned ACC_W_DEFAULT   = 10;
  localparam int unsigned CHUNK_W_DEFAULT = 5;

  typedef enum logic [1:0] {
    ACT_ZERO = 2'b00,
    ACT_POS  = 2'b01,
    ACT_NEG  = 2'b11
  } act_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

endpackage

// File: rtl/tnn_ternary_neuron_acc_if.sv
// Chunk-in / result-out handshake bundle for the ternary-neuron accumulator.
interface tnn_ternary_neuron_acc_if
  import tnn_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned ACC_W   = ACC_W_DEFAULT,
  parameter int unsigned CHUNK_W = CHUNK_W_DEFAULT
) ();

  logic                      in_valid;
  logic                      in_ready;
  logic        [CNT_W-1:0]   in_pos;
  logic        [CNT_W-1:0]   in_neg;
  logic                      in_last;
  logic signed [ACC_W-1:0]   thr_hi;
  logic signed [ACC_W-1:0]   thr_lo;
  logic                      out_valid;
  logic                      out_ready;
  act_t                      out_act;
  logic signed [ACC_W-1:0]   out_sum;
  logic        [CHUNK_W-1:0] out_chunks;
  logic                      out_ovf;

  modport master (
    output in_valid, in_pos, in_neg, in_last, thr_hi, thr_lo, out_ready,
    input  in_ready, out_valid, out_act, out_sum, out_chunks, out_ovf
  );

  modport slave (
    input  in_valid, in_pos, in_neg, in_last, thr_hi, thr_lo, out_ready,
    output in_ready, out_valid, out_act, out_sum, out_chunks, out_ovf
  );

endinterface

// File: rtl/tnn_ternary_cmp.sv
// Signed two-threshold comparator mapping a neuron sum to a ternary activation.
module tnn_ternary_cmp
  import tnn_pkg::*;
#(
  parameter int unsigned ACC_W = ACC_W_DEFAULT
) (
  input  logic [ACC_W-1:0] sum,
  input  logic [ACC_W-1:0] thr_hi,
  input  logic [ACC_W-1:0] thr_lo,
  output act_t             act
);

  // Upper threshold is tested first so an inverted band resolves to +1.
  always_comb begin
    act = ACT_ZERO;
    if ($signed(sum) >= $signed(thr_hi)) begin
      act = ACT_POS;
    end else if ($signed(sum) <= $signed(thr_lo)) begin
      act = ACT_NEG;
    end
  end

endmodule

// File: rtl/tnn_ternary_neuron_acc.sv
// Accumulates per-chunk (pos - neg) popcounts and emits a thresholded ternary activation.
// Define TNN_ACC_SAT_EN for a saturating accumulator; default build wraps.
module tnn_ternary_neuron_acc
  import tnn_pkg::*;
#(
  parameter int unsigned CNT_W   = CNT_W_DEFAULT,
  parameter int unsigned ACC_W   = ACC_W_DEFAULT,
  parameter int unsigned CHUNK_W = CHUNK_W_DEFAULT
) (
  input logic                     clk,
  input logic                     rst,
  tnn_ternary_neuron_acc_if.slave bus
);

  state_t               state_q;
  logic [ACC_W-1:0]     acc_q;
  logic [CHUNK_W-1:0]   cnt_q;
  logic                 ovf_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  act_t                 out_act_q;
  logic [ACC_W-1:0]     out_sum_q;
  logic [CHUNK_W-1:0]   out_chunks_q;
  logic                 out_ovf_q;

  logic [CNT_W:0]       diff;
  logic [ACC_W-1:0]     delta;
  logic [ACC_W-1:0]     acc_in;
  logic [ACC_W:0]       sum_wide;
  logic [ACC_W-1:0]     sum_next;
  logic                 add_ovf;
  logic                 accept;
  logic                 cnt_wrap;
  act_t                 act_next;

`ifdef TNN_ACC_SAT_EN
  localparam logic [ACC_W-1:0] SumMax = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SumMin = {1'b1, {(ACC_W-1){1'b0}}};
`endif

  // One guard bit exposes signed overflow as a mismatch of the top two bits.
  always_comb begin
    diff     = {1'b0, bus.in_pos} - {1'b0, bus.in_neg};
    delta    = {{(ACC_W-CNT_W-1){diff[CNT_W]}}, diff};
    acc_in   = (state_q == S_IDLE) ? '0 : acc_q;
    sum_wide = {acc_in[ACC_W-1], acc_in} + {delta[ACC_W-1], delta};
    add_ovf  = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];
`ifdef TNN_ACC_SAT_EN
    if (add_ovf) begin
      sum_next = sum_wide[ACC_W] ? SumMin : SumMax;
    end else begin
      sum_next = sum_wide[ACC_W-1:0];
    end
`else
    sum_next = sum_wide[ACC_W-1:0];
`endif
    accept   = bus.in_valid & in_ready_q;
    cnt_wrap = ~bus.in_last & (cnt_q == '1);
  end

  tnn_ternary_cmp #(
    .ACC_W (ACC_W)
  ) u_cmp (
    .sum    (sum_next),
    .thr_hi (bus.thr_hi),
    .thr_lo (bus.thr_lo),
    .act    (act_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      ovf_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_act_q    <= ACT_ZERO;
      out_sum_q    <= '0;
      out_chunks_q <= '0;
      out_ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_ACC: begin
          if (accept) begin
            if (bus.in_last) begin
              out_sum_q    <= sum_next;
              out_act_q    <= act_next;
              out_chunks_q <= cnt_q;
              out_ovf_q    <= ovf_q | add_ovf;
              out_valid_q  <= 1'b1;
              in_ready_q   <= 1'b0;
              state_q      <= S_OUT;
            end else begin
              acc_q   <= sum_next;
              cnt_q   <= cnt_q + CHUNK_W'(1);
              ovf_q   <= ovf_q | add_ovf | cnt_wrap;
              state_q <= S_ACC;
            end
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_act    = out_act_q;
  assign bus.out_sum    = out_sum_q;
  assign bus.out_chunks = out_chunks_q;
  assign bus.out_ovf    = out_ovf_q;

endmodule

// File: tb/tb_tnn_ternary_neuron_acc.sv
// Directed self-checking bench for tnn_ternary_neuron_acc.
module tb_tnn_ternary_neuron_acc;
  import tnn_pkg::*;

  localparam int unsigned CNT_W   = 5;
  localparam int unsigned ACC_W   = 10;
  localparam int unsigned CHUNK_W = 5;

`ifdef TNN_ACC_SAT_EN
  localparam int T4_SUM = 511;
  localparam int T4_ACT = 1;
`else
  localparam int T4_SUM = -404;
  localparam int T4_ACT = 3;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  tnn_ternary_neuron_acc_if #(
    .CNT_W   (CNT_W),
    .ACC_W   (ACC_W),
    .CHUNK_W (CHUNK_W)
  ) bus ();

  tnn_ternary_neuron_acc #(
    .CNT_W   (CNT_W),
    .ACC_W   (ACC_W),
    .CHUNK_W (CHUNK_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] observed,
                     input logic signed [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Compares every result-side output in one go.
  task automatic chk_out(input string tag, input int valid, input int sum, input int act,
                         input int chunks, input int ovf);
    chk({tag, ".valid"}, {31'd0, bus.out_valid}, valid);
    chk({tag, ".sum"}, $signed(bus.out_sum), sum);
    chk({tag, ".act"}, {30'd0, bus.out_act}, act);
    chk({tag, ".chunks"}, {27'd0, bus.out_chunks}, chunks);
    chk({tag, ".ovf"}, {31'd0, bus.out_ovf}, ovf);
  endtask

  task automatic set_thr(input int hi, input int lo);
    bus.thr_hi = ACC_W'(hi);
    bus.thr_lo = ACC_W'(lo);
  endtask

  // Starts and ends on a falling edge; one accepted beat.
  task automatic beat(input int pos, input int neg, input bit last);
    bus.in_valid = 1'b1;
    bus.in_pos   = CNT_W'(pos);
    bus.in_neg   = CNT_W'(neg);
    bus.in_last  = last;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic consume(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk({tag, ".drain_valid"}, {31'd0, bus.out_valid}, 0);
    chk({tag, ".drain_ready"}, {31'd0, bus.in_ready}, 1);
  endtask

  initial begin
    n_vec         = 0;
    n_err         = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_pos    = '0;
    bus.in_neg    = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    set_thr(10, -10);
    repeat (2) @(negedge clk);

    chk_out("reset", 0, 0, 0, 0, 0);
    chk("reset.in_ready", {31'd0, bus.in_ready}, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("reset.in_ready_after", {31'd0, bus.in_ready}, 1);

    // T1 single chunk
    beat(20, 3, 1'b1);
    chk_out("t1", 1, 17, 1, 0, 0);
    chk("t1.in_ready", {31'd0, bus.in_ready}, 0);
    consume("t1");

    // T2 three chunks, then T3 backpressure on the same result
    set_thr(5, -5);
    beat(5, 9, 1'b0);
    chk("t2.no_early_valid", {31'd0, bus.out_valid}, 0);
    beat(0, 23, 1'b0);
    beat(4, 4, 1'b1);
    chk_out("t2", 1, -27, 3, 2, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk_out("t3.hold", 1, -27, 3, 2, 0);
      chk("t3.in_ready", {31'd0, bus.in_ready}, 0);
    end
    consume("t3");

    // T4 accumulator overflow
    set_thr(100, -100);
    for (int i = 0; i < 19; i++) beat(31, 0, 1'b0);
    beat(31, 0, 1'b1);
    chk_out("t4", 1, T4_SUM, T4_ACT, 19, 1);
    consume("t4");

    // T5 zero band and inverted thresholds
    set_thr(1, -1);
    beat(0, 0, 1'b1);
    chk_out("t5.zero", 1, 0, 0, 0, 0);
    consume("t5.zero");
    beat(1, 0, 1'b1);
    chk_out("t5.plus", 1, 1, 1, 0, 0);
    consume("t5.plus");
    beat(0, 1, 1'b1);
    chk_out("t5.minus", 1, -1, 3, 0, 0);
    consume("t5.minus");
    set_thr(0, 0);
    beat(0, 0, 1'b1);
    chk_out("t5.inverted", 1, 0, 1, 0, 0);
    consume("t5.inverted");

    // Chunk counter wrap: 32 non-last beats, the 32nd sees count all-ones
    set_thr(1, -1);
    for (int i = 0; i < 32; i++) beat(0, 0, 1'b0);
    beat(0, 0, 1'b1);
    chk_out("wrap", 1, 0, 0, 0, 1);
    consume("wrap");

    // T6 reset mid-run
    beat(2, 1, 1'b0);
    beat(4, 0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("t6.no_valid", {31'd0, bus.out_valid}, 0);
      chk("t6.in_ready", {31'd0, bus.in_ready}, 1);
    end
    set_thr(10, -10);
    beat(3, 1, 1'b1);
    chk_out("t6", 1, 2, 0, 0, 0);
    consume("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
